conv2_sched: RTL and testbench

- Sequencer for the conv2 stage.
- Holds each 5x5 multi-channel window from the window buffer and steps the conv2 calc datapath through every input-channel group and output channel.
- Accumulates partial sums across groups, adds bias, saturates, and streams one 14-bit result per output channel to pool2 over valid/ready.
- Counts output positions and signals frame completion.

---
 rtl/conv2_pkg.sv | 17 +
 rtl/conv2_sat.sv | 31 +++
 rtl/conv2_sched.sv | 164 ++++++++++++++++
 tb/tb_conv2_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 stage: FSM state encoding, default widths and saturation limits.
package conv2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WIN = 3'd1,
        ACCUM    = 3'd2,
        OUTPUT   = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DW_DEF  = 14;
    localparam int AW_DEF  = 18;
    localparam int SAT_MAX = 2**(DW_DEF-1) - 1;
    localparam int SAT_MIN = -(2**(DW_DEF-1));

endpackage

// File: rtl/conv2_sat.sv
// Combinational AW->DW signed saturator with optional ReLU clamp; shared by the conv1, conv2 and fc stages.
module conv2_sat
    import conv2_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter bit RELU = 1'b0
) (
    input  logic signed [AW-1:0] din,
    output logic signed [DW-1:0] dout
);

    localparam logic signed [AW-1:0] MAX_V = AW'(2**(DW-1) - 1);
    localparam logic signed [AW-1:0] MIN_V = AW'(-(2**(DW-1)));

    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] x);
        if (x > MAX_V)
            return MAX_V[DW-1:0];
        else if (x < MIN_V)
            return MIN_V[DW-1:0];
        else
            return x[DW-1:0];
    endfunction

    always_comb begin
        dout = sat(din);
        if (RELU && dout[DW-1])
            dout = '0;
    end

endmodule

// File: rtl/conv2_sched.sv
// conv2 sequencer: walks every output channel and input group of a window, accumulates, biases, saturates and streams results.
// Build option: define CONV2_SCHED_RELU_EN to clamp negative results to zero before they are registered.
module conv2_sched
    import conv2_pkg::*;
#(
    parameter int NUM_OC  = 12,
    parameter int NUM_GRP = 2,
    parameter int OUT_W   = 8,
    parameter int OUT_H   = 8,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    localparam int GW     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
    localparam int OCW    = (NUM_OC > 1) ? $clog2(NUM_OC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 win_valid,
    output logic                 win_ack,
    output logic [GW-1:0]        grp_sel,
    output logic [OCW-1:0]       oc_sel,
    input  logic signed [DW-1:0] calc_in,
    input  logic signed [DW-1:0] bias_in,
    output logic signed [DW-1:0] out_data,
    output logic [OCW-1:0]       out_oc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int NUM_POS = OUT_W * OUT_H;
    localparam int PW      = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;

    localparam logic [GW-1:0]  G_LAST   = GW'(NUM_GRP - 1);
    localparam logic [OCW-1:0] OC_LAST  = OCW'(NUM_OC - 1);
    localparam logic [PW-1:0]  POS_LAST = PW'(NUM_POS - 1);

`ifdef CONV2_SCHED_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    state_t state, state_nxt;

    logic [GW-1:0]         g;
    logic [OCW-1:0]        oc;
    logic [PW-1:0]         pos;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  sum_p0;
    logic signed [DW-1:0]  sat_p0;
    logic                  g_last, oc_last, pos_last, accept;

    function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] x);
        return {{(AW-DW){x[DW-1]}}, x};
    endfunction

    // Final group: running sum plus this group's calc result plus bias, then clamp
    assign sum_p0 = acc + sext(calc_in) + sext(bias_in);

    conv2_sat #(
        .AW   (AW),
        .DW   (DW),
        .RELU (RELU_EN)
    ) u_sat (
        .din  (sum_p0),
        .dout (sat_p0)
    );

    assign g_last   = (g == G_LAST);
    assign oc_last  = (oc == OC_LAST);
    assign pos_last = (pos == POS_LAST);
    assign accept   = (state == OUTPUT) && out_ready;

    assign grp_sel = g;
    assign oc_sel  = oc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = WAIT_WIN;
            WAIT_WIN: if (win_valid) state_nxt = ACCUM;
            ACCUM:    if (g_last) state_nxt = OUTPUT;
            OUTPUT: begin
                if (out_ready) begin
                    if (!oc_last)
                        state_nxt = ACCUM;
                    else if (pos_last)
                        state_nxt = DONE;
                    else
                        state_nxt = WAIT_WIN;
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // win_ack fires in the accept cycle so the window buffer has advanced before WAIT_WIN samples win_valid
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        win_ack = accept && oc_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g         <= '0;
            oc        <= '0;
            pos       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_oc    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        pos <= '0;
                end
                WAIT_WIN: begin
                    if (win_valid) begin
                        g   <= '0;
                        oc  <= '0;
                        acc <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + sext(calc_in);
                    if (g_last) begin
                        out_data  <= sat_p0;
                        out_oc    <= oc;
                        out_valid <= 1'b1;
                    end else begin
                        g <= g + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        g         <= '0;
                        acc       <= '0;
                        if (oc_last) begin
                            oc  <= '0;
                            pos <= pos + 1'b1;
                        end else begin
                            oc <= oc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: per-channel vector table, result scoreboard, stall, mid-frame start and reset-abort sequences.
module tb_conv2_sched;

    localparam int DW     = 14;
    localparam int NUM_OC = 12;
    localparam int NWIN   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 win_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 win_ack, busy, done, out_valid;
    logic [0:0]           grp_sel;
    logic [3:0]           oc_sel, out_oc;
    logic signed [DW-1:0] calc_in, bias_in, out_data;

    typedef struct {
        int c0;
        int c1;
        int b;
        int exp;
    } vec_t;

    typedef struct {
        int data;
        int oc;
    } exp_t;

    vec_t tab[NUM_OC];
    exp_t sb[$];

    int n_tests = 0;
    int n_fail = 0;
    int res_cnt = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int wsel = 0;

    always #5 clk = ~clk;

    conv2_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .win_valid (win_valid),
        .win_ack   (win_ack),
        .grp_sel   (grp_sel),
        .oc_sel    (oc_sel),
        .calc_in   (calc_in),
        .bias_in   (bias_in),
        .out_data  (out_data),
        .out_oc    (out_oc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Calc datapath and bias ROM stand-ins: combinational on the selects, offset per window
    always_comb begin
        int oi;
        oi      = int'(oc_sel);
        calc_in = '0;
        bias_in = '0;
        if (oi < NUM_OC) begin
            calc_in = DW'(((grp_sel == 1'b0) ? tab[oi].c0 : tab[oi].c1) + wsel);
            bias_in = DW'(tab[oi].b);
        end
    end

    function automatic int relu(input int v);
`ifdef CONV2_SCHED_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int model(input int a, input int b, input int c);
        int s;
        s = a + b + c;
        if (s > 8191)
            s = 8191;
        else if (s < -8192)
            s = -8192;
        return relu(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_win_ack"}, win_ack, 0);
        check({pfx, "_grp_sel"}, grp_sel, 0);
        check({pfx, "_oc_sel"}, oc_sel, 0);
        check({pfx, "_out_data"}, out_data, 0);
        check({pfx, "_out_oc"}, out_oc, 0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    task automatic push_win(input int w);
        for (int i = 0; i < NUM_OC; i++) begin
            exp_t e;
            e.oc = i;
            if (w == 0)
                e.data = relu(tab[i].exp);
            else
                e.data = model(tab[i].c0 + w, tab[i].c1 + w, tab[i].b);
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: a result counts as accepted when valid and ready are both high mid-cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                res_cnt++;
                check("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_oc", out_oc, e.oc);
                end
            end
            if (win_ack) begin
                ack_cnt++;
                check("ack_on_last_accept", (out_valid && out_ready && out_oc == 4'd11) ? 1 : 0, 1);
            end
            if (done)
                done_cnt++;
        end
    end

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (win_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic first_window(output bit ok);
        int n;
        bit hold;
        logic signed [DW-1:0] d;
        logic [3:0] o, s;
        ok = 1'b1;
        hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || oc_sel != 4'd0 || win_ack) hold = 1'b0;
        end
        check("wait_win_idle", hold, 1);
        @(posedge clk);
        #1 win_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_result_latency", n, 2);
        n = 0;
        while (!(out_valid && out_oc == 4'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("reach_oc2_timeout", 0, 1);
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("stall_oc", out_oc, 3);
        check("stall_data", out_data, relu(tab[3].exp));
        d = out_data;
        o = out_oc;
        s = oc_sel;
        hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== d || out_oc !== o || oc_sel !== s || win_ack)
                hold = 1'b0;
        end
        check("stall_stable", hold, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
    endtask

    task automatic frame(input bit special, input int abort_w);
        bit ok;
        res_cnt = 0;
        ack_cnt = 0;
        done_cnt = 0;
        wsel = 0;
        sb.delete();
        win_valid = !special;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        for (int w = 0; w < NWIN; w++) begin
            push_win(w);
            if (w == abort_w) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1 check_zero("abort");
                sb.delete();
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (5) @(negedge clk);
                check("abort_no_done", done_cnt, 0);
                check("abort_idle", busy, 0);
                return;
            end
            if (special && w == 0) begin
                first_window(ok);
                if (!ok) return;
            end
            if (w == 5) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_ack(ok);
            if (!ok) begin
                check("ack_timeout", 0, 1);
                return;
            end
            @(posedge clk);
            #1;
            if (w < NWIN - 1) wsel = w + 1;
        end
        start = 1'b1;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_low_after_done", busy, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
    endtask

    task automatic check_counts(input string pfx);
        check({pfx, "_results"}, res_cnt, NWIN * NUM_OC);
        check({pfx, "_win_acks"}, ack_cnt, NWIN);
        check({pfx, "_done_pulses"}, done_cnt, 1);
        check({pfx, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0]  = '{100, 200, 5, 305};
        tab[1]  = '{8000, 8000, 100, 8191};
        tab[2]  = '{-8000, -8000, 0, -8192};
        tab[3]  = '{0, 0, -3, -3};
        tab[4]  = '{-100, 50, 7, -43};
        tab[5]  = '{4000, 4000, 191, 8191};
        tab[6]  = '{4000, 4000, 192, 8191};
        tab[7]  = '{-4000, -4000, -192, -8192};
        tab[8]  = '{-4000, -4000, -193, -8192};
        tab[9]  = '{8000, 8000, -8192, 7808};
        tab[10] = '{1, -1, 0, 0};
        tab[11] = '{-8000, 7999, -8192, -8192};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        frame(1'b1, -1);
        check_counts("frame1");

        frame(1'b0, 10);

        frame(1'b0, -1);
        check_counts("frame3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
